// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, IEEE-754 single field widths, divider state
// encoding and flag bundle.
package fpu_pkg;

  localparam logic [3:0] FPU_OP_DIV  = 4'd3;
  localparam logic [3:0] FPU_OP_PASS = 4'd9;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned SEXP_W = 10;
  localparam int unsigned QBITS  = 26;
  localparam int unsigned CNT_W  = 5;

  localparam logic [SEXP_W-1:0] EXP_BIAS  = 10'd127;
  localparam logic [31:0]       QNAN      = 32'h7FC0_0000;
  localparam logic [30:0]       INF_MAG   = {8'hFF, 23'h0};
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(QBITS - 1);

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_UNPACK,
    DIV_DIVIDE,
    DIV_NORM,
    DIV_DONE
  } div_state_t;

  typedef struct packed {
    logic div_zero;
    logic invalid;
    logic overflow;
    logic underflow;
  } div_flags_t;

endpackage

// File: rtl/fpu_unpack.sv
// Combinational IEEE-754 single field split and classification; denormals
// report a zero mantissa so callers can flush them.
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]       i_op,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_is_zero,
  output logic              o_is_inf,
  output logic              o_is_nan,
  output logic              o_is_denorm
);

  logic [FRAC_W-1:0] w_frac;
  logic              w_exp_min;
  logic              w_exp_max;
  logic              w_frac_nz;

  assign o_sign    = i_op[31];
  assign o_exp     = i_op[30:23];
  assign w_frac    = i_op[22:0];
  assign w_exp_min = (o_exp == '0);
  assign w_exp_max = (o_exp == '1);
  assign w_frac_nz = (w_frac != '0);

  assign o_is_zero   = w_exp_min & ~w_frac_nz;
  assign o_is_denorm = w_exp_min &  w_frac_nz;
  assign o_is_inf    = w_exp_max & ~w_frac_nz;
  assign o_is_nan    = w_exp_max &  w_frac_nz;
  assign o_mant      = w_exp_min ? '0 : {1'b1, w_frac};

endmodule

// File: rtl/fpu_div_seq.sv
// Iterative IEEE-754 single divider, radix-2 restoring, one quotient bit per
// cycle. Define FPU_DIV_ROUND_NEAREST_EN for round-to-nearest-even (default truncation).
module fpu_div_seq
  import fpu_pkg::*;
#(
  parameter logic [3:0] DIV_OPCODE = FPU_OP_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  operation,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_zero,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow
);

`ifdef FPU_DIV_ROUND_NEAREST_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  div_state_t               r_state;
  div_state_t               w_state_nxt;
  logic [31:0]              r_a;
  logic [31:0]              r_b;
  logic                     r_sign;
  logic signed [SEXP_W-1:0] r_exp;
  logic [MANT_W-1:0]        r_mb;
  logic [MANT_W:0]          r_rem;
  logic [QBITS-1:0]         r_q;
  logic [CNT_W-1:0]         r_cnt;
  logic [31:0]              r_pend_res;
  div_flags_t               r_pend_flags;
  logic                     r_busy;
  logic                     r_done;
  logic [31:0]              r_result;
  div_flags_t               r_flags;

  logic                     w_accept;

  logic                     w_ua_sign, w_ub_sign;
  logic [EXP_W-1:0]         w_ua_exp, w_ub_exp;
  logic [MANT_W-1:0]        w_ua_mant, w_ub_mant;
  logic                     w_ua_zero, w_ua_inf, w_ua_nan, w_ua_dn;
  logic                     w_ub_zero, w_ub_inf, w_ub_nan, w_ub_dn;
  logic                     w_a_zero, w_b_zero;
  logic                     w_sign;
  logic                     w_bad;
  logic                     w_special;
  logic [31:0]              w_sp_res;
  div_flags_t               w_sp_flags;
  logic [SEXP_W-1:0]        w_exp_raw;

  logic                     w_ge;
  logic [MANT_W:0]          w_diff;
  logic [MANT_W:0]          w_rem_nxt;

  logic                     w_hi;
  logic [FRAC_W-1:0]        w_frac;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_inc;
  logic                     w_carry;
  logic [FRAC_W-1:0]        w_frac_r;
  logic signed [SEXP_W-1:0] w_exp_n;
  logic signed [SEXP_W-1:0] w_exp_f;
  logic [31:0]              w_nm_res;
  div_flags_t               w_nm_flags;

  assign w_accept = start && (operation == DIV_OPCODE);

  fpu_unpack u_unpack_a (
    .i_op        (r_a),
    .o_sign      (w_ua_sign),
    .o_exp       (w_ua_exp),
    .o_mant      (w_ua_mant),
    .o_is_zero   (w_ua_zero),
    .o_is_inf    (w_ua_inf),
    .o_is_nan    (w_ua_nan),
    .o_is_denorm (w_ua_dn)
  );

  fpu_unpack u_unpack_b (
    .i_op        (r_b),
    .o_sign      (w_ub_sign),
    .o_exp       (w_ub_exp),
    .o_mant      (w_ub_mant),
    .o_is_zero   (w_ub_zero),
    .o_is_inf    (w_ub_inf),
    .o_is_nan    (w_ub_nan),
    .o_is_denorm (w_ub_dn)
  );

  // Denormals are flushed, so they classify as zero from here on.
  assign w_a_zero  = w_ua_zero | w_ua_dn;
  assign w_b_zero  = w_ub_zero | w_ub_dn;
  assign w_sign    = w_ua_sign ^ w_ub_sign;
  assign w_bad     = w_ua_nan | w_ub_nan | (w_a_zero & w_b_zero) | (w_ua_inf & w_ub_inf);
  assign w_special = w_bad | w_ua_inf | w_ub_inf | w_a_zero | w_b_zero;
  assign w_exp_raw = {2'b00, w_ua_exp} - {2'b00, w_ub_exp} + EXP_BIAS;

  always_comb begin
    w_sp_res   = {w_sign, 31'h0};
    w_sp_flags = '0;
    if (w_bad) begin
      w_sp_res           = QNAN;
      w_sp_flags.invalid = 1'b1;
    end else if (w_ua_inf) begin
      w_sp_res = {w_sign, INF_MAG};
    end else if (w_b_zero) begin
      w_sp_res            = {w_sign, INF_MAG};
      w_sp_flags.div_zero = 1'b1;
    end
  end

  // Remainder stays below 2*mb, so 25 bits always suffice.
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_diff    = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_nxt = w_diff << 1;

  assign w_hi     = r_q[QBITS-1];
  assign w_frac   = w_hi ? r_q[24:2] : r_q[23:1];
  assign w_guard  = w_hi ? r_q[1]    : r_q[0];
  assign w_sticky = (w_hi & r_q[0]) | (r_rem != '0);
  assign w_exp_n  = w_hi ? r_exp : (r_exp - 10'sd1);
  assign w_inc    = RNE_EN & w_guard & (w_sticky | w_frac[0]);

  // A carry out of the fraction leaves it zero, i.e. mantissa 0x800000 one binade up.
  assign {w_carry, w_frac_r} = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_inc};
  assign w_exp_f = w_carry ? (w_exp_n + 10'sd1) : w_exp_n;

  always_comb begin
    w_nm_res   = {r_sign, w_exp_f[7:0], w_frac_r};
    w_nm_flags = '0;
    if (w_exp_f >= 10'sd255) begin
      w_nm_res            = {r_sign, INF_MAG};
      w_nm_flags.overflow = 1'b1;
    end else if (w_exp_f <= 10'sd0) begin
      w_nm_res             = {r_sign, 31'h0};
      w_nm_flags.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DIV_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE:   if (w_accept) w_state_nxt = DIV_UNPACK;
      DIV_UNPACK: w_state_nxt = w_special ? DIV_DONE : DIV_DIVIDE;
      DIV_DIVIDE: if (r_cnt == LAST_STEP) w_state_nxt = DIV_NORM;
      DIV_NORM:   w_state_nxt = DIV_DONE;
      DIV_DONE:   w_state_nxt = DIV_IDLE;
      default:    w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sign       <= 1'b0;
      r_exp        <= '0;
      r_mb         <= '0;
      r_rem        <= '0;
      r_q          <= '0;
      r_cnt        <= '0;
      r_pend_res   <= '0;
      r_pend_flags <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_flags      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_flags <= '0;
          end
        end
        DIV_UNPACK: begin
          r_sign       <= w_sign;
          r_exp        <= $signed(w_exp_raw);
          r_mb         <= w_ub_mant;
          r_rem        <= {1'b0, w_ua_mant};
          r_q          <= '0;
          r_cnt        <= '0;
          r_pend_res   <= w_sp_res;
          r_pend_flags <= w_sp_flags;
        end
        DIV_DIVIDE: begin
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 5'd1;
        end
        DIV_NORM: begin
          r_pend_res   <= w_nm_res;
          r_pend_flags <= w_nm_flags;
        end
        DIV_DONE: begin
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_result <= r_pend_res;
          r_flags  <= r_pend_flags;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign div_zero  = r_flags.div_zero;
  assign invalid   = r_flags.invalid;
  assign overflow  = r_flags.overflow;
  assign underflow = r_flags.underflow;

endmodule
